imm_packer: RTL

- Streaming immediate encoder. It is the inverse of the core's immediate sign-extension decode.
- Takes a base instruction word, a format op and a 32-bit immediate value. Scatters the immediate into the format's instruction bit fields and checks that the value is representable.
- Used by the debug instruction injector and the test-ROM patcher to build branch, jump and load/store words at run time.
- Two-stage valid/ready pipeline with a saturating range-error counter.

---
 rtl/imm_pkg.sv | 35 +++
 rtl/imm_field_pack.sv | 54 +++++
 rtl/imm_packer.sv | 102 ++++++++++
 3 files changed

// File: rtl/imm_pkg.sv
// Immediate format codes and instruction field positions, shared by the
// immediate packer and the core decoder's sign-extension stage.
package imm_pkg;

   localparam logic [2:0] IMM_NONE  = 3'b000;
   localparam logic [2:0] IMM_I     = 3'b001;
   localparam logic [2:0] IMM_SHAMT = 3'b010;
   localparam logic [2:0] IMM_S     = 3'b011;
   localparam logic [2:0] IMM_B     = 3'b100;
   localparam logic [2:0] IMM_U     = 3'b101;
   localparam logic [2:0] IMM_J     = 3'b110;
   localparam logic [2:0] IMM_ILL   = 3'b111;

   localparam int INST_MSB   = 31;
   localparam int I_LSB      = 20;
   localparam int SHAMT_MSB  = 24;
   localparam int SHAMT_LSB  = 20;
   localparam int S_HI_LSB   = 25;
   localparam int S_LO_MSB   = 11;
   localparam int S_LO_LSB   = 7;
   localparam int B_B11_POS  = 7;
   localparam int B_LO_LSB   = 8;
   localparam int U_LSB      = 12;
   localparam int J_MID_MSB  = 19;
   localparam int J_B11_POS  = 20;
   localparam int J_LO_LSB   = 21;

   // True when v[31:msb] are all equal, i.e. v survives sign-extension from bit msb.
   function automatic logic fits_signed(input logic [31:0] v, input int unsigned msb);
      logic [31:0] s;
      s = $signed(v) >>> msb;
      return (s == '0) || (s == '1);
   endfunction

endpackage

// File: rtl/imm_field_pack.sv
// Combinational scatter of an immediate into the instruction fields of one
// format, with a representability check on the original value.
module imm_field_pack
   import imm_pkg::*;
(
   input  logic [2:0]  op,
   input  logic [31:0] inst,
   input  logic [31:0] imm,
   output logic [31:0] inst_packed,
   output logic        range_err
);

   // Fields are always packed from the low bits, even when range_err is set.
   always_comb begin
      inst_packed = inst;
      range_err   = 1'b0;
      case (op)
         IMM_I: begin
            inst_packed[INST_MSB:I_LSB] = imm[11:0];
            range_err = !fits_signed(imm, 11);
         end
         IMM_SHAMT: begin
            inst_packed[SHAMT_MSB:SHAMT_LSB] = imm[4:0];
            range_err = (imm[31:5] != '0);
         end
         IMM_S: begin
            inst_packed[INST_MSB:S_HI_LSB] = imm[11:5];
            inst_packed[S_LO_MSB:S_LO_LSB] = imm[4:0];
            range_err = !fits_signed(imm, 11);
         end
         IMM_B: begin
            inst_packed[INST_MSB]             = imm[12];
            inst_packed[B_B11_POS]            = imm[11];
            inst_packed[INST_MSB-1:S_HI_LSB]  = imm[10:5];
            inst_packed[S_LO_MSB:B_LO_LSB]    = imm[4:1];
            range_err = !fits_signed(imm, 12) || imm[0];
         end
         IMM_U: begin
            inst_packed[INST_MSB:U_LSB] = imm[31:12];
            range_err = (imm[11:0] != '0);
         end
         IMM_J: begin
            inst_packed[INST_MSB]             = imm[20];
            inst_packed[J_MID_MSB:U_LSB]      = imm[19:12];
            inst_packed[J_B11_POS]            = imm[11];
            inst_packed[INST_MSB-1:J_LO_LSB]  = imm[10:1];
            range_err = !fits_signed(imm, 20) || imm[0];
         end
         IMM_ILL: range_err = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: rtl/imm_packer.sv
// Two-stage valid/ready immediate encoder: S1 captures the request, S2 holds
// the packed word and error flag; a saturating counter tallies range errors.
module imm_packer
   import imm_pkg::*;
#(
   parameter int ERR_CNT_W = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [2:0]           in_op,
   input  logic [31:0]          in_inst,
   input  logic [31:0]          in_imm,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [31:0]          out_inst,
   output logic                 out_err,
   output logic [ERR_CNT_W-1:0] err_cnt,
   input  logic                 err_clr
);

   localparam logic [ERR_CNT_W-1:0] CNT_ONE = 1;
   localparam logic [ERR_CNT_W-1:0] CNT_MAX = '1;

   logic                 s1_valid;
   logic [2:0]           s1_op;
   logic [31:0]          s1_inst;
   logic [31:0]          s1_imm;
   logic                 s2_valid;
   logic [31:0]          s2_inst;
   logic                 s2_err;
   logic [ERR_CNT_W-1:0] cnt;
   logic                 s1_advance;
   logic                 s2_advance;
   logic                 s2_load;
   logic [31:0]          packed_inst;
   logic                 packed_err;

   // Valid/ready: a beat moves on a rising edge when valid & ready are both
   // high; valid and data are held until then, and a stage advances whenever
   // it is empty or the stage after it advances, so bubbles collapse.
   assign s2_advance = !s2_valid || out_ready;
   assign s1_advance = !s1_valid || s2_advance;
   assign s2_load    = s1_valid && s2_advance;
   assign in_ready   = s1_advance;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_op    <= IMM_NONE;
         s1_inst  <= '0;
         s1_imm   <= '0;
      end else if (s1_advance) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_op   <= in_op;
            s1_inst <= in_inst;
            s1_imm  <= in_imm;
         end
      end
   end

   imm_field_pack u_pack (
      .op          (s1_op),
      .inst        (s1_inst),
      .imm         (s1_imm),
      .inst_packed (packed_inst),
      .range_err   (packed_err)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s2_valid <= 1'b0;
         s2_inst  <= '0;
         s2_err   <= 1'b0;
      end else if (s2_advance) begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            s2_inst <= packed_inst;
            s2_err  <= packed_err;
         end
      end
   end

   // A clear wins over an increment landing in the same cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (err_clr) begin
         cnt <= '0;
      end else if (s2_load && packed_err && (cnt != CNT_MAX)) begin
         cnt <= cnt + CNT_ONE;
      end
   end

   assign out_valid = s2_valid;
   assign out_inst  = s2_inst;
   assign out_err   = s2_err;
   assign err_cnt   = cnt;

endmodule
